cpu_rmw_unit: RTL
=================

// Module: cpu_rmw_unit
// PURPOSE
//  Sequencer for 6502 read-modify-write memory instructions (ASL/LSR/ROL/ROR/INC/DEC abs/zp).
//  Sits between the CPU control path and the CPU ALU: fetches the operand, drives the ALU
//  (add/sub/shr/shl encodings), issues the 6502 dummy write of the unmodified value, writes
//  the result, and hands N/Z/C back to the status register.
// PARAMETERS
//  ADDR_W  16  memory address width
// PORTS
//  clk         in   1       system clock, all state on rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  start       in   1       request pulse; sampled only when busy=0
//  op          in   3       0 ASL, 1 LSR, 2 ROL, 3 ROR, 4 INC, 5 DEC; 6/7 illegal
//  addr        in   ADDR_W  effective address of operand, sampled with start
//  carry_in    in   1       current P.C, sampled with start
//  busy        out  1       high from cycle after accepted start until done cycle (exclusive)
//  done        out  1       one-cycle pulse after final write accepted
//  mem_addr    out  ADDR_W  bus address (latched addr while busy, else 0)
//  mem_rd      out  1       read strobe
//  mem_wr      out  1       write strobe
//  mem_wdata   out  8       write data
//  mem_rdata   in   8       read data, valid when mem_rd & mem_ready
//  mem_ready   in   1       bus ack (RDY); low stalls current state
//  alu_a       out  8       ALU operand A (latched operand)
//  alu_b       out  8       ALU operand B (1 for INC/DEC, else 0)
//  alu_op      out  3       ALU op: 0 add, 1 sub, 5 shr, 6 shl
//  alu_cin     out  1       ALU carry in
//  alu_out     in   8       ALU result
//  alu_cout    in   1       ALU carry out
//  flag_n      out  1       result[7], valid with done
//  flag_z      out  1       result==0, valid with done
//  flag_c      out  1       ALU carry out, valid with done
//  flag_c_we   out  1       1 with done for shift/rotate ops only; 0 for INC/DEC
// BEHAVIOUR
//  Reset: state IDLE; busy, done, mem_rd, mem_wr, flag_* = 0; mem_addr, mem_wdata, op/operand/result regs = 0.
//  Reset mid-operation: strobes drop asynchronously, no further bus cycles, no done.
//  States: IDLE -> READ -> DUMMY -> WRITE -> IDLE.
//   IDLE : start & op<=5 latches op, addr, carry_in; next READ. op>=6 ignored (stays IDLE, no done).
//   READ : mem_rd=1. On mem_ready: operand <= mem_rdata; next DUMMY.
//   DUMMY: mem_wr=1, mem_wdata=operand (unmodified). ALU driven from operand; on mem_ready:
//          result <= alu_out, carry <= alu_cout; next WRITE.
//   WRITE: mem_wr=1, mem_wdata=result. On mem_ready: next IDLE, done=1 for one cycle with flags.
//  ALU mapping: ASL shl cin0; LSR shr cin0; ROL shl cin=P.C; ROR shr cin=P.C; INC add b=1 cin0;
//   DEC sub b=1 cin1. alu_* held constant through stalls; registered outputs only (no bus glitch).
//  mem_ready low: state, strobes, address and data held unchanged indefinitely.
//  Latency, mem_ready=1: start sampled at edge 0; READ cycle 1, DUMMY 2, WRITE 3, done cycle 4.
//  start while busy=1 ignored. start in done cycle is accepted (state already IDLE).
//  flag_* hold last values until next done; flag_c_we only high during done.
// TESTING
//  ASL, addr 0x0010=0x81, C=0 -> rd 0x0010; wr 0x81 then 0x02; done cyc 4, C=1 N=0 Z=0 c_we=1.
//  ROR, operand 0x01, C=1 -> wr 0x01 then 0x80; N=1 Z=0 C=1.
//  INC, operand 0xFF -> wr 0xFF then 0x00; Z=1 N=0, flag_c_we=0.
//  DEC 0x00, mem_ready low 3 cycles in DUMMY -> addr/wdata/strobes frozen; final 0xFF N=1, done cyc 7.
//  rst_n low during WRITE -> mem_wr=0 at once, busy=0, no done; start while busy and op=6 ignored.
//  Back-to-back: start in done cycle -> second READ immediately next cycle, correct results both.

Source files
------------

// File: rtl/cpu_rmw_unit.sv
// rtl/cpu_rmw_unit.sv - 6502 read-modify-write sequencer (read, dummy write, result write)
module cpu_rmw_unit #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic              carry_in,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [2:0]        alu_op,
  output logic              alu_cin,
  input  logic [7:0]        alu_out,
  input  logic              alu_cout,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_c_we
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DUMMY, S_WRITE} state_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_SHR = 3'd5;
  localparam logic [2:0] ALU_SHL = 3'd6;

  state_t     state;
  logic [2:0] op_q;
  logic       carry_q;
  logic [7:0] operand;
  logic [7:0] result;
  logic       carry_res;

  logic [2:0] alu_op_nx;
  logic [7:0] alu_b_nx;
  logic       alu_cin_nx;

  // Operand A is the fetched byte itself, so it stays stable across DUMMY stalls.
  assign alu_a = operand;

  always_comb begin
    alu_op_nx  = ALU_SHL;
    alu_b_nx   = 8'd0;
    alu_cin_nx = 1'b0;
    case (op_q)
      3'd0: alu_op_nx = ALU_SHL;
      3'd1: alu_op_nx = ALU_SHR;
      3'd2: begin alu_op_nx = ALU_SHL; alu_cin_nx = carry_q; end
      3'd3: begin alu_op_nx = ALU_SHR; alu_cin_nx = carry_q; end
      3'd4: begin alu_op_nx = ALU_ADD; alu_b_nx = 8'd1; end
      3'd5: begin alu_op_nx = ALU_SUB; alu_b_nx = 8'd1; alu_cin_nx = 1'b1; end
      default: alu_op_nx = ALU_SHL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= 3'd0;
      carry_q   <= 1'b0;
      operand   <= 8'd0;
      result    <= 8'd0;
      carry_res <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wdata <= 8'd0;
      alu_b     <= 8'd0;
      alu_op    <= 3'd0;
      alu_cin   <= 1'b0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_c_we <= 1'b0;
    end else begin
      done      <= 1'b0;
      flag_c_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && op <= 3'd5) begin
            op_q     <= op;
            carry_q  <= carry_in;
            mem_addr <= addr;
            mem_rd   <= 1'b1;
            busy     <= 1'b1;
            state    <= S_READ;
          end
        end
        S_READ: begin
          if (mem_ready) begin
            operand   <= mem_rdata;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b1;
            mem_wdata <= mem_rdata;
            alu_b     <= alu_b_nx;
            alu_op    <= alu_op_nx;
            alu_cin   <= alu_cin_nx;
            state     <= S_DUMMY;
          end
        end
        S_DUMMY: begin
          // The unmodified byte is on the bus this cycle; the ALU result goes out next.
          if (mem_ready) begin
            result    <= alu_out;
            carry_res <= alu_cout;
            mem_wdata <= alu_out;
            state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (mem_ready) begin
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            flag_n    <= result[7];
            flag_z    <= (result == 8'd0);
            flag_c    <= carry_res;
            flag_c_we <= (op_q <= 3'd3);
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
